// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared types for the collision checker arbiter
package tetris_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        REQ_DROP  = 2'd0,
        REQ_LEFT  = 2'd1,
        REQ_RIGHT = 2'd2,
        REQ_ROT   = 2'd3
    } req_id_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_CLR    = 3'd3,
        S_SETTLE = 3'd4
    } arb_state_t;

endpackage

// File: rtl/collision_arb_rr_pick.sv
// rtl/collision_arb_rr_pick.sv - round-robin pick of the first pending requester at or after ptr
module rr_pick
    import tetris_pkg::*;
(
    input  logic [N_REQ-1:0] pend,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       id
);

    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        any = 1'b0;
        id  = ptr;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (pend[idx]) begin
                any = 1'b1;
                id  = idx;
            end
        end
    end

endmodule

// File: rtl/collision_arb.sv
// rtl/collision_arb.sv - arbitrates four move requesters onto the shared collision checker
module collision_arb
    import tetris_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       chk_ready,
    input  logic       chk_hit,
    input  logic       chk_free,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       chk_start,
    output logic       chk_clr,
    output logic       done,
    output logic [1:0] done_id,
    output logic       done_ok,
    output logic       lock,
    output logic       err
);

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t     state;
    arb_state_t     state_nx;
    logic [3:0]     pend;
    logic [1:0]     ptr;
    logic [CW-1:0]  cnt;
    logic           res_ok;
    logic           res_err;

    logic           pick_any;
    logic [1:0]     pick_id;
    logic           grant;
    logic [3:0]     grant_mask;
    logic           verdict;
    logic           v_ok;
    logic           v_err;

    rr_pick u_pick (
        .pend (pend),
        .ptr  (ptr),
        .any  (pick_any),
        .id   (pick_id)
    );

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        verdict  = 1'b0;
        v_ok     = 1'b0;
        v_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && pick_any && chk_ready) begin
                    grant    = 1'b1;
                    state_nx = S_START;
                end
            end
            S_START: state_nx = S_WAIT;
            S_WAIT: begin
                // A hit dominates; hit together with free is a checker fault.
                if (chk_hit) begin
                    verdict = 1'b1;
                    v_err   = chk_free;
                end else if (chk_free) begin
                    verdict = 1'b1;
                    v_ok    = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    verdict = 1'b1;
                    v_err   = 1'b1;
                end
                if (verdict) begin
                    state_nx = S_CLR;
                end
            end
            S_CLR: state_nx = S_SETTLE;
            S_SETTLE: begin
                if (chk_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign grant_mask = grant ? (4'b0001 << pick_id) : 4'b0000;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= S_IDLE;
            pend    <= '0;
            ptr     <= '0;
            cnt     <= '0;
            sel     <= '0;
            res_ok  <= 1'b0;
            res_err <= 1'b0;
        end else begin
            state <= state_nx;
            // A new request on the granted bit in the grant cycle survives the clear.
            pend  <= en ? ((pend & ~grant_mask) | req) : '0;
            if (grant) begin
                sel <= pick_id;
            end
            if (state != S_WAIT) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CW'(1);
            end
            if (verdict) begin
                res_ok  <= v_ok;
                res_err <= v_err;
            end
            if (state == S_CLR) begin
                ptr <= sel + 2'd1;
            end
        end
    end

    assign sel_valid = (state != S_IDLE);
    assign chk_start = (state == S_START);
    assign chk_clr   = (state == S_CLR);
    assign done      = (state == S_CLR);
    assign done_id   = done ? sel : 2'd0;
    assign done_ok   = done & res_ok;
    assign lock      = done & ~res_ok & (sel == REQ_DROP);
    assign err       = done & res_err;

endmodule

// File: tb/tb_collision_arb.sv
// tb/tb_collision_arb.sv - scoreboard bench for collision_arb with a behavioural checker
module tb_collision_arb;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'd0;
    logic       chk_ready = 1'b1;
    logic       chk_hit = 1'b0;
    logic       chk_free = 1'b0;
    logic [1:0] sel;
    logic       sel_valid;
    logic       chk_start;
    logic       chk_clr;
    logic       done;
    logic [1:0] done_id;
    logic       done_ok;
    logic       lock;
    logic       err;

    collision_arb #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .en        (en),
        .req       (req),
        .chk_ready (chk_ready),
        .chk_hit   (chk_hit),
        .chk_free  (chk_free),
        .sel       (sel),
        .sel_valid (sel_valid),
        .chk_start (chk_start),
        .chk_clr   (chk_clr),
        .done      (done),
        .done_id   (done_id),
        .done_ok   (done_ok),
        .lock      (lock),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pending set, pointer, expected results.
    typedef struct {
        int id;
        int ok;
        int lock;
        int err;
        int due;
    } exp_t;

    exp_t       exq[$];
    int         gnt_log[$];
    logic [3:0] m_pend = 4'd0;
    logic [3:0] m_prev = 4'd0;
    logic [3:0] l_req = 4'd0;
    logic       l_en = 1'b0;
    logic       l_ready = 1'b0;
    int         m_ptr = 0;
    bit         prev_done = 1'b0;

    int  next_kind = 0;   // 0 free, 1 hit, 2 both, 3 never answers
    int  next_lat  = 1;
    bit  rand_mode = 1'b0;

    function automatic int rr(input logic [3:0] p, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (p[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!Reset_n) begin
            m_pend  = 4'd0;
            m_prev  = 4'd0;
            l_req   = 4'd0;
            l_en    = 1'b0;
            l_ready = 1'b0;
        end else begin
            m_prev  = m_pend;
            m_pend  = en ? (m_pend | req) : 4'd0;
            l_req   = req;
            l_en    = en;
            l_ready = chk_ready;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!Reset_n) begin
            exq.delete();
            m_ptr     = 0;
            prev_done = 1'b0;
        end else begin
            if (chk_start) begin
                int   id;
                exp_t e;
                check("start_ready_at_grant", int'(l_ready), 1);
                check("start_en_at_grant", int'(l_en), 1);
                check("start_sel_valid", int'(sel_valid), 1);
                check("one_outstanding", exq.size(), 0);
                id = rr(m_prev, m_ptr);
                check("grant_id", int'(sel), id);
                if (id >= 0) m_pend = m_pend & ~((4'b0001 << id) & ~l_req);
                e.id   = id;
                e.ok   = (next_kind == 0) ? 1 : 0;
                e.err  = (next_kind >= 2) ? 1 : 0;
                e.lock = (id == 0 && e.ok == 0) ? 1 : 0;
                e.due  = (next_kind == 3) ? cyc + 1 + TO : cyc + next_lat + 1;
                exq.push_back(e);
                gnt_log.push_back(int'(sel));
            end
            if (done) begin
                check("done_not_back_to_back", int'(prev_done), 0);
                check("done_has_expectation", int'(exq.size() > 0), 1);
                if (exq.size() > 0) begin
                    exp_t e;
                    e = exq.pop_front();
                    check("done_id", int'(done_id), e.id);
                    check("done_ok", int'(done_ok), e.ok);
                    check("lock", int'(lock), e.lock);
                    check("err", int'(err), e.err);
                    check("chk_clr_with_done", int'(chk_clr), 1);
                    check("done_cycle", cyc, e.due);
                    m_ptr = (e.id + 1) % 4;
                end
            end
            prev_done = done;
        end
    end

    // Behavioural collision checker
    int ck_cnt  = 0;
    int ck_kind = 0;
    int ck_rdly = 0;
    bit ck_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!Reset_n) begin
                chk_ready = 1'b1;
                chk_hit   = 1'b0;
                chk_free  = 1'b0;
                ck_busy   = 1'b0;
            end else if (chk_clr) begin
                chk_hit  = 1'b0;
                chk_free = 1'b0;
                ck_busy  = 1'b0;
                ck_rdly  = $urandom_range(0, 2);
                if (ck_rdly == 0) chk_ready = 1'b1;
            end else if (chk_start) begin
                chk_ready = 1'b0;
                ck_busy   = 1'b1;
                ck_kind   = next_kind;
                ck_cnt    = next_lat;
                if (rand_mode) begin
                    next_kind = $urandom_range(0, 3);
                    next_lat  = $urandom_range(1, 5);
                end
            end else if (ck_busy) begin
                ck_cnt--;
                if (ck_cnt == 0 && ck_kind != 3) begin
                    chk_hit  = (ck_kind == 1 || ck_kind == 2);
                    chk_free = (ck_kind == 0 || ck_kind == 2);
                end
            end else if (!chk_ready) begin
                ck_rdly--;
                if (ck_rdly <= 0) chk_ready = 1'b1;
            end
        end
    end

    task automatic pulse(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(negedge clk);
        req = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        Reset_n = 1'b0;
        req = 4'd0;
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        Reset_n = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < max_cyc && !idle; i++) begin
            @(negedge clk);
            #2;
            idle = (exq.size() == 0) && (m_pend == 4'd0) && !sel_valid;
        end
        check("drain_to_idle", int'(idle), 1);
    endtask

    task automatic wait_start(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            seen = chk_start;
        end
        check("wait_chk_start", int'(seen), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"}, int'(sel), 0);
        check({tag, "_sel_valid"}, int'(sel_valid), 0);
        check({tag, "_chk_start"}, int'(chk_start), 0);
        check({tag, "_chk_clr"}, int'(chk_clr), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_done_id"}, int'(done_id), 0);
        check({tag, "_done_ok"}, int'(done_ok), 0);
        check({tag, "_lock"}, int'(lock), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n_start;
        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        #2;
        Reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Single request: start at t+2, done at t+4
        en = 1'b1;
        next_kind = 0;
        next_lat = 1;
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = 4'd0;
        check("single_no_start_t1", int'(chk_start), 0);
        @(negedge clk);
        check("single_start_t2", int'(chk_start), 1);
        check("single_sel_t2", int'(sel), 2);
        wait_idle(50);

        // All four at once, every check blocked
        do_reset();
        en = 1'b1;
        next_kind = 1;
        next_lat = 2;
        gnt_log.delete();
        pulse(4'b1111);
        wait_idle(200);
        check("all4_count", gnt_log.size(), 4);

        // Fairness: req[0] refreshed after each done while req[3] waits
        do_reset();
        en = 1'b1;
        next_kind = 0;
        next_lat = 1;
        gnt_log.delete();
        pulse(4'b1001);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40 && !done; i++) @(negedge clk);
            req = 4'b0001;
            @(negedge clk);
            req = 4'd0;
        end
        wait_idle(200);
        check("fair_rot_second", (gnt_log.size() > 1) ? gnt_log[1] : -1, 3);

        // Timeout, then conflicting verdict on a drop
        next_kind = 3;
        pulse(4'b0010);
        wait_idle(100);
        next_kind = 2;
        next_lat = 3;
        pulse(4'b0001);
        wait_idle(100);

        // en drops during S_WAIT with req[1] pending
        next_kind = 1;
        next_lat = 5;
        pulse(4'b0001);
        wait_start(20);
        req = 4'b0010;
        @(negedge clk);
        req = 4'd0;
        en = 1'b0;
        n_start = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (chk_start) n_start++;
        end
        check("en_low_no_start", n_start, 0);
        en = 1'b1;
        wait_idle(50);

        // Randomized traffic
        rand_mode = 1'b1;
        next_kind = $urandom_range(0, 3);
        next_lat = $urandom_range(1, 5);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            req = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            en = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        req = 4'd0;
        en = 1'b1;
        rand_mode = 1'b0;
        wait_idle(400);

        // Asynchronous reset while waiting on the checker
        next_kind = 3;
        pulse(4'b0100);
        wait_start(40);
        @(negedge clk);
        check("pre_reset_sel_valid", int'(sel_valid), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        #2;
        Reset_n = 1'b1;
        en = 1'b1;
        next_kind = 0;
        next_lat = 2;
        gnt_log.delete();
        pulse(4'b1010);
        wait_idle(100);
        check("post_reset_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
